// File: rtl/sw_pkg.sv
// Shared types and defaults for the stopwatch controller.
package sw_pkg;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEFAULT_TICK_DIV        = 100;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_LAP   = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      LAP   = ST_LAP
   } sw_state_t;

endpackage

// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, counter debouncer, and
// registered rising-edge detector producing a single-cycle press pulse.
module btn_conditioner
   import sw_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic nrst,
   input  logic async_in,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          deb_q;
   logic          deb_dly_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         press_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= async_in;
         sync2_q   <= sync1_q;
         deb_dly_q <= deb_q;
         press_q   <= deb_q & ~deb_dly_q;
         // Accept the new level on the edge the mismatch run would hit DEBOUNCE_CYCLES.
         if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
               deb_q <= sync2_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions three buttons, runs the IDLE/RUN/PAUSE/LAP
// state machine and generates the count tick from a phase-preserving prescaler.
module stopwatch_ctrl
   import sw_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned TICK_DIV        = DEFAULT_TICK_DIV
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       pb_start,
   input  logic       pb_lap,
   input  logic       pb_clear,
   output logic       run_en,
   output logic       tick,
   output logic       lap_hold,
   output logic       clear,
   output logic [1:0] state
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   logic      press_start;
   logic      press_lap;
   logic      press_clear;
   sw_state_t state_q;
   sw_state_t state_d;
   logic      clear_q;
   logic      clear_d;
   logic [PW-1:0] presc_q;

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
      .clk      (clk),
      .nrst     (nrst),
      .async_in (pb_start),
      .press    (press_start)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
      .clk      (clk),
      .nrst     (nrst),
      .async_in (pb_lap),
      .press    (press_lap)
   );

   btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
      .clk      (clk),
      .nrst     (nrst),
      .async_in (pb_clear),
      .press    (press_clear)
   );

   // Priority clear > start > lap; losing presses are simply dropped.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (press_clear) begin
         state_d = IDLE;
         clear_d = 1'b1;
      end else if (press_start) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            LAP:     state_d = PAUSE;
            default: state_d = IDLE;
         endcase
      end else if (press_lap) begin
         case (state_q)
            RUN:     state_d = LAP;
            LAP:     state_d = RUN;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         clear_q <= 1'b0;
         presc_q <= '0;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
         if (clear_d) begin
            presc_q <= '0;
         end else if (run_en) begin
            presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
         end
      end
   end

   assign run_en   = (state_q == RUN) || (state_q == LAP);
   assign lap_hold = (state_q == LAP);
   assign tick     = run_en && (presc_q == PRESC_MAX);
   assign clear    = clear_q;
   assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       pb_start = 1'b0;
   logic       pb_lap = 1'b0;
   logic       pb_clear = 1'b0;
   logic       run_en;
   logic       tick;
   logic       lap_hold;
   logic       clear;
   logic [1:0] state;

   int pass_cnt = 0;
   int total_cnt = 0;
   int tick_cnt = 0;
   int clear_cnt = 0;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_LAP   = 2'b11;

   stopwatch_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_DIV(10)) u_dut (
      .clk      (clk),
      .nrst     (nrst),
      .pb_start (pb_start),
      .pb_lap   (pb_lap),
      .pb_clear (pb_clear),
      .run_en   (run_en),
      .tick     (tick),
      .lap_hold (lap_hold),
      .clear    (clear),
      .state    (state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick) tick_cnt++;
      if (clear) clear_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      pb_start = 1'b0;
      pb_lap   = 1'b0;
      pb_clear = 1'b0;
      nrst     = 1'b0;
      step(2);
      nrst     = 1'b1;
   endtask

   // Leaves the DUT in RUN, 16 edges after reset release, prescaler at 8.
   task automatic get_to_run();
      do_reset();
      pb_start = 1'b1;
      step(6);
      pb_start = 1'b0;
      step(10);
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      #1;
      total_cnt++;
      if ({state, run_en, tick, lap_hold, clear} !== 6'b0)
         $display("FAIL reset_outputs got=%b want=000000", {state, run_en, tick, lap_hold, clear});
      else pass_cnt++;
      step(2);
      nrst = 1'b1;
      step(3);
      total_cnt++;
      if ({state, run_en, tick, lap_hold, clear} !== 6'b0)
         $display("FAIL post_reset_idle got=%b want=000000", {state, run_en, tick, lap_hold, clear});
      else pass_cnt++;
   endtask

   task automatic test_start_hold();
      do_reset();
      tick_cnt = 0;
      pb_start = 1'b1;
      step(7);
      total_cnt++;
      if (state !== S_IDLE) $display("FAIL start_edge7 state=%b want=%b", state, S_IDLE);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (state !== S_RUN || run_en !== 1'b1)
         $display("FAIL start_edge8 state=%b run_en=%b want=%b/1", state, run_en, S_RUN);
      else pass_cnt++;
      step(8);
      total_cnt++;
      if (tick !== 1'b0) $display("FAIL tick_early got=%b want=0", tick);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (tick !== 1'b1) $display("FAIL first_tick got=%b want=1", tick);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (tick !== 1'b0) $display("FAIL tick_width got=%b want=0", tick);
      else pass_cnt++;
      step(2);
      pb_start = 1'b0;
      step(7);
      total_cnt++;
      if (tick !== 1'b1) $display("FAIL second_tick got=%b want=1", tick);
      else pass_cnt++;
      step(10);
      total_cnt++;
      if (state !== S_RUN || tick_cnt !== 2)
         $display("FAIL hold_one_press state=%b ticks=%0d want=%b/2", state, tick_cnt, S_RUN);
      else pass_cnt++;
   endtask

   task automatic test_glitch();
      do_reset();
      pb_start = 1'b1;
      step(3);
      pb_start = 1'b0;
      step(15);
      total_cnt++;
      if (state !== S_IDLE || run_en !== 1'b0)
         $display("FAIL glitch state=%b run_en=%b want=%b/0", state, run_en, S_IDLE);
      else pass_cnt++;
   endtask

   task automatic test_pause_resume();
      get_to_run();
      pb_start = 1'b1;
      step(6);
      pb_start = 1'b0;
      step(2);
      total_cnt++;
      if (state !== S_PAUSE || run_en !== 1'b0 || tick !== 1'b0)
         $display("FAIL pause state=%b run_en=%b tick=%b want=%b/0/0", state, run_en, tick, S_PAUSE);
      else pass_cnt++;
      step(8);
      tick_cnt = 0;
      step(20);
      total_cnt++;
      if (tick_cnt !== 0) $display("FAIL pause_silent ticks=%0d want=0", tick_cnt);
      else pass_cnt++;
      pb_start = 1'b1;
      step(8);
      total_cnt++;
      if (state !== S_RUN) $display("FAIL resume state=%b want=%b", state, S_RUN);
      else pass_cnt++;
      step(2);
      total_cnt++;
      if (tick !== 1'b0) $display("FAIL resume_tick_early got=%b want=0", tick);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (tick !== 1'b1) $display("FAIL resume_phase got=%b want=1", tick);
      else pass_cnt++;
      pb_start = 1'b0;
      step(10);
   endtask

   task automatic test_lap();
      get_to_run();
      pb_lap = 1'b1;
      step(8);
      total_cnt++;
      if (state !== S_LAP || lap_hold !== 1'b1 || run_en !== 1'b1)
         $display("FAIL lap_enter state=%b lap_hold=%b run_en=%b want=%b/1/1",
                  state, lap_hold, run_en, S_LAP);
      else pass_cnt++;
      step(3);
      total_cnt++;
      if (tick !== 1'b1) $display("FAIL lap_tick got=%b want=1", tick);
      else pass_cnt++;
      pb_lap = 1'b0;
      step(13);
      pb_lap = 1'b1;
      step(8);
      total_cnt++;
      if (state !== S_RUN || lap_hold !== 1'b0 || run_en !== 1'b1)
         $display("FAIL lap_exit state=%b lap_hold=%b run_en=%b want=%b/0/1",
                  state, lap_hold, run_en, S_RUN);
      else pass_cnt++;
      pb_lap = 1'b0;
      step(12);
   endtask

   task automatic test_clear_priority();
      get_to_run();
      clear_cnt = 0;
      pb_start = 1'b1;
      pb_clear = 1'b1;
      step(8);
      total_cnt++;
      if (state !== S_IDLE || clear !== 1'b1 || run_en !== 1'b0)
         $display("FAIL clear_edge state=%b clear=%b run_en=%b want=%b/1/0", state, clear, run_en, S_IDLE);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (clear !== 1'b0) $display("FAIL clear_width got=%b want=0", clear);
      else pass_cnt++;
      pb_start = 1'b0;
      pb_clear = 1'b0;
      step(12);
      total_cnt++;
      if (state !== S_IDLE || clear_cnt !== 1)
         $display("FAIL clear_hold state=%b clears=%0d want=%b/1", state, clear_cnt, S_IDLE);
      else pass_cnt++;
      pb_start = 1'b1;
      step(8);
      step(8);
      total_cnt++;
      if (tick !== 1'b0) $display("FAIL presc_cleared_early got=%b want=0", tick);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (tick !== 1'b1) $display("FAIL presc_cleared got=%b want=1", tick);
      else pass_cnt++;
      pb_start = 1'b0;
      step(10);
   endtask

   task automatic test_start_over_lap();
      get_to_run();
      pb_start = 1'b1;
      pb_lap   = 1'b1;
      step(8);
      total_cnt++;
      if (state !== S_PAUSE || lap_hold !== 1'b0)
         $display("FAIL start_over_lap state=%b lap_hold=%b want=%b/0", state, lap_hold, S_PAUSE);
      else pass_cnt++;
      pb_start = 1'b0;
      pb_lap   = 1'b0;
      step(10);
   endtask

   task automatic test_reset_mid();
      get_to_run();
      pb_lap = 1'b1;
      step(6);
      pb_lap = 1'b0;
      step(10);
      total_cnt++;
      if (state !== S_LAP) $display("FAIL mid_setup state=%b want=%b", state, S_LAP);
      else pass_cnt++;
      pb_start = 1'b1;
      step(3);
      nrst = 1'b0;
      #1;
      total_cnt++;
      if ({state, run_en, tick, lap_hold, clear} !== 6'b0)
         $display("FAIL mid_reset got=%b want=000000", {state, run_en, tick, lap_hold, clear});
      else pass_cnt++;
      pb_start = 1'b0;
      step(2);
      nrst = 1'b1;
      tick_cnt = 0;
      clear_cnt = 0;
      step(20);
      total_cnt++;
      if (state !== S_IDLE || tick_cnt !== 0 || clear_cnt !== 0)
         $display("FAIL mid_no_pulse state=%b ticks=%0d clears=%0d want=%b/0/0",
                  state, tick_cnt, clear_cnt, S_IDLE);
      else pass_cnt++;
      pb_start = 1'b1;
      nrst = 1'b0;
      step(2);
      nrst = 1'b1;
      step(7);
      total_cnt++;
      if (state !== S_IDLE) $display("FAIL held_reset_edge7 state=%b want=%b", state, S_IDLE);
      else pass_cnt++;
      step(1);
      total_cnt++;
      if (state !== S_RUN) $display("FAIL held_reset_edge8 state=%b want=%b", state, S_RUN);
      else pass_cnt++;
      pb_start = 1'b0;
      step(10);
   endtask

   initial begin
      step(1);
      test_reset();
      test_start_hold();
      test_glitch();
      test_pause_resume();
      test_lap();
      test_clear_priority();
      test_start_over_lap();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a button level change is accepted (minimum 1).
REQ-002 Parameter TICK_DIV, default 100: clock cycles per count tick (minimum 2).
REQ-003 clk  in  1  system clock; all flops rising-edge.
REQ-004 nrst  in  1  reset, asynchronous, active-low.
REQ-005 pb_start  in  1  raw start/stop pushbutton, asynchronous, active-high.
REQ-006 pb_lap  in  1  raw lap pushbutton, asynchronous, active-high.
REQ-007 pb_clear  in  1  raw clear pushbutton, asynchronous, active-high.
REQ-008 run_en  out  1  count enable to the downstream timer/counter.
REQ-009 tick  out  1  one-cycle count strobe to the downstream timer/counter.
REQ-010 lap_hold  out  1  freezes the downstream display while counting continues.
REQ-011 clear  out  1  one-cycle clear strobe to the downstream timer/counter.
REQ-012 state  out  2  current FSM state encoding.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer, then a rising-edge detector.
REQ-014 Debouncer: a counter SHALL increment each cycle the synchronized level differs from the debounced level, and SHALL reset to 0 when they match.
REQ-015 The debounced level SHALL take the synchronized value on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no press.
REQ-017 Press pulse: registered, high for exactly 1 cycle, asserted after edge DEBOUNCE_CYCLES+3, where edge 1 is the first edge sampling the button high.
REQ-018 Holding a button SHALL yield exactly one press; release SHALL yield none.
REQ-019 FSM states: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, LAP=2'b11.
REQ-020 FSM transitions occur on the edge after a press pulse (edge DEBOUNCE_CYCLES+4).
REQ-021 Start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE.
REQ-022 Lap press: RUN->LAP, LAP->RUN; ignored in IDLE and PAUSE.
REQ-023 Clear press: any state ->IDLE; clear SHALL be high for exactly the 1 cycle following that transition edge.
REQ-024 Simultaneous presses: priority clear > start > lap; lower-priority presses in the same cycle SHALL be discarded.
REQ-025 run_en=1 in RUN and LAP, else 0; lap_hold=1 only in LAP; outputs registered or decoded from state only (no combinational input paths).
REQ-026 Prescaler: counts 0..TICK_DIV-1 while run_en=1 and wraps to 0.
REQ-027 tick SHALL be high in the cycle the prescaler equals TICK_DIV-1 and run_en=1.
REQ-028 The prescaler SHALL hold its value while run_en=0, so PAUSE/resume preserves sub-tick phase.
REQ-029 The prescaler SHALL reset to 0 on the clear transition.

Reset
REQ-030 nrst low SHALL asynchronously clear all synchronizer, debounce, edge, and prescaler flops to 0 and force state=IDLE.
REQ-031 During reset, run_en=0, tick=0, lap_hold=0, clear=0, state=2'b00.
REQ-032 A button held through reset release SHALL produce a press after normal debounce, since the debounced level restarts at 0.
REQ-033 Reset mid-debounce or mid-tick SHALL discard the partial count with no spurious pulse.

Structure
REQ-034 Shared package sw_pkg SHALL hold typedef sw_state_t (enum with REQ-019 encodings) and the default DEBOUNCE_CYCLES/TICK_DIV constants.
REQ-035 Sub-module btn_conditioner (clk, nrst, async_in -> press) SHALL implement REQ-013..REQ-018 and be instantiated three times.
REQ-036 The FSM and prescaler SHALL reside in stopwatch_ctrl.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=10)
REQ-037 Test 1: pb_start high 20 cycles from IDLE -> state=RUN after edge 8, run_en=1, exactly one press; first tick 10 cycles later, then every 10.
REQ-038 Test 2: pb_start 3-cycle glitch -> no state change, no press.
REQ-039 Test 3: In RUN at prescaler=6, press start -> PAUSE with tick silent and prescaler held at its value. Press start again -> RUN; next tick fires when the count resumes and reaches 9.
REQ-040 Test 4: RUN, press lap -> LAP: lap_hold=1, run_en=1, ticks continue. Press lap -> RUN: lap_hold=0.
REQ-041 Test 5: pb_start and pb_clear pressed together in RUN -> IDLE, clear high 1 cycle, run_en=0, prescaler=0.
REQ-042 Test 6: Assert nrst mid-debounce while in LAP -> all outputs 0 and state=IDLE immediately. No pulse after release unless a button is still held.
